btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Conditions the raw push-button pins (BtnC, BtnU, BtnL, BtnR, BtnD) before they reach the game logic and the movement controller. Each button is synchronised, debounced, and converted into a clean held level plus single-cycle press and release strobes. The block sits between the board pins and `block_controller`. It runs on the 100 MHz board clock, so game logic can use edge events instead of relying on a slow `move_clk` to mask bounce.

## Interface
- `NUM_BTNS`, 5, number of independent buttons; bit order {D, R, L, U, C}, MSB first.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable synchronised samples required to accept a change (10 ms at 100 MHz); must be ≥ 2.
- `REPEAT_DELAY`, 50_000_000, cycles in HELD before the first auto-repeat strobe (macro-dependent).
- `REPEAT_PERIOD`, 10_000_000, cycles between subsequent auto-repeat strobes (macro-dependent).
- `clk`  in  1  board clock (ClkPort).
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `btn_raw`  in  NUM_BTNS  asynchronous raw button pins, active-high.
- `btn_level`  out  NUM_BTNS  debounced held state.
- `btn_press`  out  NUM_BTNS  one-cycle strobe on accepted press, and on each auto-repeat.
- `btn_release`  out  NUM_BTNS  one-cycle strobe on accepted release.

## Operation
- Synchroniser: two flops per bit; `sync` is the second flop. Both flops are cleared by `rst`.
- Per-button FSM, states IDLE, PRESS_WAIT, HELD, REL_WAIT, and a per-button counter of width clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).
- IDLE: if `sync`=1, go to PRESS_WAIT with cnt=1; otherwise stay.
- PRESS_WAIT:
  - If `sync`=0, return to IDLE with cnt=0 (bounce is rejected).
  - Else if cnt = DEBOUNCE_CYCLES-1, go to HELD, cnt=0, assert `btn_press` for that cycle.
  - Else cnt+1.
- HELD: if `sync`=0, go to REL_WAIT with cnt=1; otherwise stay (see Configuration for repeat).
- REL_WAIT:
  - If `sync`=1, return to HELD with cnt=0; no strobe is generated.
  - Else if cnt = DEBOUNCE_CYCLES-1, go to IDLE and assert `btn_release`.
  - Else cnt+1.
- `btn_level` = 1 exactly in HELD and REL_WAIT.
- Counters saturate and never wrap. The counter compare uses the full width; no truncation is allowed.
- Buttons are fully independent. Simultaneous presses on several bits each produce their own strobe in the same cycle.
- A button held through reset deassertion is treated as a fresh press: the synchroniser fills, the FSM passes through PRESS_WAIT, then HELD, and `btn_press` fires.
- `rst` mid-debounce or mid-HELD: the next cycle is IDLE with all outputs 0. No release strobe is emitted.

## Timing
- Reset values: `btn_level`=0, `btn_press`=0, `btn_release`=0; all FSMs in IDLE; counters 0.
- All outputs are registered and driven directly from FSM state or state-transition flops, with no combinational path from `btn_raw`.
- Press latency: `btn_raw` rises before edge k and stays clean. `sync` is high after edge k+1. `btn_press` and `btn_level` assert after edge k+1+DEBOUNCE_CYCLES.
- Release latency has the same structure; `btn_level` deasserts in the cycle `btn_release` is high.
- Strobes are exactly one cycle wide. `btn_press` and `btn_release` are never high together for the same bit.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - In HELD, cnt counts while `sync`=1.
  - At cnt = REPEAT_DELAY-1, assert `btn_press` and load cnt=0 in a repeat phase (one extra flag bit per button).
  - Thereafter, assert `btn_press` each time cnt = REPEAT_PERIOD-1.
  - Any move to REL_WAIT clears the phase flag. Returning from REL_WAIT to HELD restarts the REPEAT_DELAY count.
- Not defined: HELD generates no further strobes. REPEAT_DELAY and REPEAT_PERIOD are ignored and do not widen the counter.

## Structure
- Shared package `btn_pkg`: state enum (IDLE, PRESS_WAIT, HELD, REL_WAIT), button index constants (BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4), default cycle constants.
- Sub-module `btn_debounce_fsm`: one button containing the synchroniser, counter and FSM. The top generate-loops it NUM_BTNS times.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5.
- Clean press on bit 1 held for 40 cycles, no macro -> `btn_press`[1] is a single pulse 10 cycles after the raw rise; `btn_level`[1]=1 from that cycle; no further strobes.
- Raw toggles 1/0 every 3 cycles for 30 cycles, then holds 1 -> no strobe during bouncing; exactly one press 10 cycles after the final stable rise.
- Release glitch: in HELD, raw drops for 4 cycles and returns -> `btn_level` stays 1 and no `btn_release`. A later clean drop yields `btn_release` 10 cycles after the fall.
- Bits 0 and 4 rise on the same cycle -> both `btn_press` bits pulse in the same cycle.
- `rst` asserted for 1 cycle mid-HELD with raw still 1 -> outputs are 0 the next cycle; a new `btn_press` arrives 10 cycles after `rst` drops; no `btn_release`.
- `BTN_AUTOREPEAT_EN` defined, held for 40 cycles after acceptance -> press strobes at acceptance, +20, +25, +30, +35.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM states, button indices and default timing for btn_conditioner.
package btn_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} btn_state_t;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    localparam int DEF_NUM_BTNS        = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

    // Repeat timings only widen the counter when auto-repeat is built in.
    function automatic int cnt_width(int db, int rd, int rp, bit repeat_en);
        int m;
        m = db;
        if (repeat_en) begin
            m = (rd > m) ? rd : m;
            m = (rp > m) ? rp : m;
        end
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/btn_debounce_fsm.sv
// btn_debounce_fsm: synchroniser, debounce counter and press/release FSM for one button.
// Defining BTN_AUTOREPEAT_EN adds repeated press strobes while the button is held.
module btn_debounce_fsm
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);
`ifdef BTN_AUTOREPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif
    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, REPEAT_EN);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
`endif

    btn_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n, inc;
    logic meta, sync, phase, phase_n, press_n, rel_n;

    assign inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign level = (state == HELD) || (state == REL_WAIT);

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        phase_n = phase;
        press_n = 1'b0;
        rel_n = 1'b0;
        case (state)
            IDLE: if (sync) begin
                state_n = PRESS_WAIT;
                cnt_n = CW'(1);
            end
            PRESS_WAIT: if (!sync) begin
                state_n = IDLE;
                cnt_n = '0;
            end else if (cnt == DB_LAST) begin
                state_n = HELD;
                cnt_n = '0;
                press_n = 1'b1;
            end else cnt_n = inc;
            HELD: if (!sync) begin
                state_n = REL_WAIT;
                cnt_n = CW'(1);
                phase_n = 1'b0;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (cnt == (phase ? RP_LAST : RD_LAST)) begin
                cnt_n = '0;
                phase_n = 1'b1;
                press_n = 1'b1;
            end else cnt_n = inc;
`endif
            REL_WAIT: if (sync) begin
                state_n = HELD;
                cnt_n = '0;
            end else if (cnt == DB_LAST) begin
                state_n = IDLE;
                cnt_n = '0;
                rel_n = 1'b1;
            end else cnt_n = inc;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            phase <= 1'b0;
            press <= 1'b0;
            rel <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            state <= state_n;
            cnt <= cnt_n;
            phase <= phase_n;
            press <= press_n;
            rel <= rel_n;
        end
    end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button sync, debounce and press/release strobes, bits {D,R,L,U,C}.
// Auto-repeat of btn_press is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTNS        = DEF_NUM_BTNS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release
);
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_fsm (
            .clk(clk),
            .rst(rst),
            .raw(btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel(btn_release[i])
        );
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios plus random bouncing buttons against a run-length model.
module tb_btn_conditioner;
    localparam int NB = 5, DB = 8, RD = 20, RP = 5;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    int errors = 0, checks = 0;
    bit chk_en = 1'b0;

    // Model: a button changes its accepted level after DB consecutive disagreeing sync samples.
    logic [NB-1:0] s1 = '0, s2 = '0, lvl = '0, exp_p = '0, exp_r = '0;
    int run [NB];
    int held [NB];
    bit rearm [NB];

    always #5 clk = ~clk;

    btn_conditioner #(
        .NUM_BTNS(NB),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            s1 = '0;
            s2 = '0;
            lvl = '0;
            exp_p = '0;
            exp_r = '0;
            for (int b = 0; b < NB; b++) begin
                run[b] = 0;
                held[b] = 0;
                rearm[b] = 1'b0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                exp_p[b] = 1'b0;
                exp_r[b] = 1'b0;
                if (s2[b] == lvl[b]) begin
                    run[b] = 0;
                    if (lvl[b] && rearm[b]) begin
                        rearm[b] = 1'b0;
                        held[b] = 0;
                    end else if (lvl[b]) begin
                        held[b]++;
                        if (AR && held[b] >= RD && (held[b] - RD) % RP == 0) exp_p[b] = 1'b1;
                    end
                end else begin
                    run[b]++;
                    if (lvl[b]) rearm[b] = 1'b1;
                    if (run[b] == DB) begin
                        lvl[b] = ~lvl[b];
                        run[b] = 0;
                        held[b] = 0;
                        rearm[b] = 1'b0;
                        exp_p[b] = lvl[b];
                        exp_r[b] = ~lvl[b];
                    end
                end
            end
            s2 = s1;
            s1 = btn_raw;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_level", btn_level, lvl);
            chk("model_press", btn_press, exp_p);
            chk("model_release", btn_release, exp_r);
            chk("press_release_exclusive", btn_press & btn_release, '0);
        end
    end

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_level", btn_level, '0);
        chk("reset_press", btn_press, '0);
        chk("reset_release", btn_release, '0);
        rst = 1'b0;

        btn_raw[1] = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            chk("clean_press", NB'(btn_press[1]),
                NB'(i == 10 || (AR && i >= 30 && (i - 30) % RP == 0)));
            chk("clean_level", NB'(btn_level[1]), NB'(i >= 10));
        end
        btn_raw[1] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("clean_release", NB'(btn_release[1]), NB'(i == 10));
        end

        for (int i = 0; i < 30; i++) begin
            btn_raw[2] = ((i / 3) % 2) == 0;
            tick();
            chk("bounce_quiet", NB'(btn_press[2]), '0);
        end
        btn_raw[2] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("bounce_press", NB'(btn_press[2]), NB'(i == 10));
        end
        btn_raw[2] = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        btn_raw[3] = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        for (int i = 0; i < 16; i++) begin
            btn_raw[3] = i >= 4;
            tick();
            chk("glitch_level", NB'(btn_level[3]), NB'(1));
            chk("glitch_no_release", NB'(btn_release[3]), '0);
        end
        btn_raw[3] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("glitch_release", NB'(btn_release[3]), NB'(i == 10));
        end

        btn_raw = 5'b10001;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("simul_press", btn_press, (i == 10) ? 5'b10001 : 5'b00000);
        end
        btn_raw = '0;
        for (int i = 0; i < 12; i++) tick();

        btn_raw = 5'b00001;
        for (int i = 0; i < 14; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_level", btn_level, '0);
        chk("rst_press", btn_press, '0);
        chk("rst_release", btn_release, '0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("rst_repress", btn_press, NB'(i == 10));
            chk("rst_no_release", btn_release, '0);
        end
        btn_raw = '0;
        for (int i = 0; i < 12; i++) tick();

        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, ((n / 400) % 2 == 1) ? 9 : 39) == 0) btn_raw[b] = ~btn_raw[b];
            rst = $urandom_range(0, 599) == 0;
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
